// File: rtl/mem_pkg.sv
// Shared widths, command record and FSM encodings for the memory transaction driver.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // One queued command: rd=1 for a read, rd=0 for a write.
  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef logic [2:0] drv_state_t;

  localparam drv_state_t ST_IDLE    = 3'd0;
  localparam drv_state_t ST_WRITE   = 3'd1;
  localparam drv_state_t ST_READ    = 3'd2;
  localparam drv_state_t ST_CAPTURE = 3'd3;
  localparam drv_state_t ST_RESP    = 3'd4;

  // Event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Command FIFO: DEPTH entries of mem_cmd_t, show-ahead read port.
module mem_cmd_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_cmd_t push_data,
  input  logic     pop,
  output mem_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  mem_cmd_t         store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is visible combinationally so the FSM can decode it on the pop cycle.
  assign pop_data = store[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: payload array is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_txn_driver.sv
// Transaction front end for a 32x8 synchronous memory: queues read/write
// commands, sequences the memory pins one command at a time and returns read data.
module mem_txn_driver
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count,
  output logic [7:0]        err_count
);

  drv_state_t state;
  drv_state_t state_next;
  mem_cmd_t   push_data;
  mem_cmd_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       cmd_fire;
  logic       cmd_legal;
  logic       push;
  logic       pop;
  logic       rsp_fire;

  assign cmd_ready = !fifo_full;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_legal = cmd_read ^ cmd_write;
  assign push      = cmd_fire && cmd_legal;
  assign push_data = '{rd: cmd_read, addr: cmd_addr, wdata: cmd_wdata};
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign rsp_fire  = (state == ST_RESP) && rsp_ready;

  mem_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pin strobes decode straight from state so reset drops them without waiting for a clock.
  assign mem_write = (state == ST_WRITE);
  assign mem_read  = (state == ST_READ);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = !fifo_empty || (state != ST_IDLE);

  // Next-state decode for the command sequencer.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) state_next = head.rd ? ST_READ : ST_WRITE;
      ST_WRITE:   state_next = ST_IDLE;
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Memory address/data pins: loaded when a command leaves the FIFO, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else if (pop) begin
      mem_addr <= head.addr;
      if (!head.rd) mem_data_in <= head.wdata;
    end
  end

  // Response payload: memory output is valid the cycle after the read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else if (state == ST_CAPTURE) begin
      rsp_addr  <= mem_addr;
      rsp_rdata <= mem_data_out;
    end
  end

  // Saturating activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      if (state == ST_WRITE)       wr_count  <= sat_inc(wr_count);
      if (rsp_fire)                rd_count  <= sat_inc(rd_count);
      if (cmd_fire && !cmd_legal)  err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_mem_txn_driver.sv
// Directed self-checking bench for mem_txn_driver with a behavioural 32x8 memory.
module tb_mem_txn_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_read;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       busy;
  logic [7:0] wr_count;
  logic [7:0] rd_count;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  mem_txn_driver dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_read     (cmd_read),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_addr     (rsp_addr),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .wr_count     (wr_count),
    .rd_count     (rd_count),
    .err_count    (err_count)
  );

  // Behavioural synchronous memory: write on the edge, read data registered on the edge.
  logic [7:0] mem_model [32];
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem_model[mem_addr];
  end

  // Passive monitors: response handshakes, issued writes, strobe overlap.
  logic [12:0] rsp_q[$];
  logic [12:0] wlog[$];
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          excl_err  = 0;
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) rsp_q.push_back({rsp_addr, rsp_rdata});
    if (mem_write) begin
      wlog.push_back({mem_addr, mem_data_in});
      wr_pulses++;
    end
    if (mem_read) rd_pulses++;
    if (mem_read && mem_write) excl_err++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic rd, input logic wr, input logic [4:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("send_cmd ready timeout", cmd_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    if (busy) check(tag, busy, 0);
  endtask

  int base;
  int wbase;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst mem_read",  mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst busy",      busy, 0);
    check("rst counters",  {wr_count, rd_count, err_count}, 0);
    check("rst pins",      {mem_addr, mem_data_in, rsp_addr, rsp_rdata}, 0);
    check("rst cmd_ready", cmd_ready, 1);
    rst = 1'b0;

    // Test 1: zero-fill then read back; first write checks E+2 latency
    send_cmd(1'b0, 1'b1, 5'd0, 8'h00);
    @(negedge clk);
    check("t1 write latency early", mem_write, 0);
    @(negedge clk);
    check("t1 write latency pulse", mem_write, 1);
    check("t1 write addr", mem_addr, 0);
    for (int i = 1; i < 32; i++) send_cmd(1'b0, 1'b1, 5'(i), 8'h00);
    base = rsp_q.size();
    for (int i = 0; i < 32; i++) send_cmd(1'b1, 1'b0, 5'(i), 8'h5A);
    wait_idle("t1 idle timeout");
    check("t1 rsp count", rsp_q.size() - base, 32);
    if (rsp_q.size() >= base + 32)
      for (int i = 0; i < 32; i++) begin
        check("t1 rsp_addr",  rsp_q[base+i][12:8], i);
        check("t1 rsp_rdata", rsp_q[base+i][7:0], 0);
      end
    check("t1 wr_count",  wr_count, 32);
    check("t1 rd_count",  rd_count, 32);
    check("t1 err_count", err_count, 0);

    // Test 2: data = address pattern
    for (int i = 0; i < 32; i++) send_cmd(1'b0, 1'b1, 5'(i), 8'(i));
    base = rsp_q.size();
    for (int i = 0; i < 32; i++) send_cmd(1'b1, 1'b0, 5'(i), 8'hFF);
    wait_idle("t2 idle timeout");
    check("t2 rsp count", rsp_q.size() - base, 32);
    if (rsp_q.size() >= base + 32)
      for (int i = 0; i < 32; i++) begin
        check("t2 rsp_addr",  rsp_q[base+i][12:8], i);
        check("t2 rsp_rdata", rsp_q[base+i][7:0], i);
      end
    check("t2 wr_count", wr_count, 64);
    check("t2 rd_count", rd_count, 64);

    // Test 3: illegal commands are accepted and dropped
    base  = rd_pulses;
    wbase = wr_pulses;
    send_cmd(1'b1, 1'b1, 5'd7, 8'h11);
    send_cmd(1'b0, 1'b0, 5'd8, 8'h22);
    repeat (4) @(negedge clk);
    check("t3 err_count", err_count, 2);
    check("t3 no read pulse",  rd_pulses - base, 0);
    check("t3 no write pulse", wr_pulses - wbase, 0);
    check("t3 busy", busy, 0);
    check("t3 wr_count", wr_count, 64);

    // Test 4: response backpressure fills the FIFO
    rsp_ready = 1'b0;
    base  = rsp_q.size();
    wbase = wlog.size();
    send_cmd(1'b1, 1'b0, 5'd3, 8'h00);
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 1'b1, 5'(10 + i), 8'(8'hA0 + i));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 5'd14;
    cmd_wdata = 8'hA4;
    repeat (3) @(negedge clk);
    check("t4 cmd_ready full", cmd_ready, 0);
    check("t4 rsp_valid held", rsp_valid, 1);
    check("t4 rsp_addr",  rsp_addr, 3);
    check("t4 rsp_rdata", rsp_rdata, 3);
    repeat (3) @(negedge clk);
    check("t4 rsp stable", {rsp_valid, rsp_addr, rsp_rdata}, {1'b1, 5'd3, 8'd3});
    check("t4 busy", busy, 1);
    check("t4 no writes yet", wr_count, 64);
    rsp_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!cmd_ready) check("t4 ready timeout", cmd_ready, 1);
      else begin
        @(posedge clk);
        #1;
      end
      cmd_valid = 1'b0;
    end
    wait_idle("t4 idle timeout");
    check("t4 rsp count", rsp_q.size() - base, 1);
    check("t4 write count", wlog.size() - wbase, 5);
    if (wlog.size() >= wbase + 5)
      for (int i = 0; i < 5; i++) check("t4 write order", wlog[wbase+i], {5'(10 + i), 8'(8'hA0 + i)});
    check("t4 wr_count", wr_count, 69);
    check("t4 rd_count", rd_count, 65);

    // Test 5: async reset while the read strobe is high
    send_cmd(1'b1, 1'b0, 5'd9, 8'h00);
    begin
      int n;
      n = 0;
      while (!mem_read && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5 reached READ", mem_read, 1);
    #1 rst = 1'b1;
    #1;
    check("t5 mem_read dropped", mem_read, 0);
    check("t5 rsp_valid", rsp_valid, 0);
    check("t5 counters", {wr_count, rd_count, err_count}, 0);
    check("t5 busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    base = rsp_q.size();
    send_cmd(1'b1, 1'b0, 5'd5, 8'h00);
    @(negedge clk);
    check("t5 lat idle", {mem_read, rsp_valid}, 0);
    @(negedge clk);
    check("t5 lat read", {mem_read, mem_addr}, {1'b1, 5'd5});
    @(negedge clk);
    check("t5 lat capture", {mem_read, rsp_valid}, 0);
    @(negedge clk);
    check("t5 lat resp", {rsp_valid, rsp_addr, rsp_rdata}, {1'b1, 5'd5, 8'd5});
    wait_idle("t5 idle timeout");
    check("t5 rsp count", rsp_q.size() - base, 1);
    check("t5 rd_count", rd_count, 1);
    check("t5 wr_count", wr_count, 0);

    // Test 6: write counter saturation
    for (int i = 0; i < 300; i++) send_cmd(1'b0, 1'b1, 5'd20, 8'(i));
    wait_idle("t6 idle timeout");
    check("t6 wr_count sat", wr_count, 8'hFF);
    check("t6 rd_count", rd_count, 1);
    check("t6 last data", mem_data_in, 8'(299));
    check("strobe exclusivity", excl_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
